nor_universal_shift_reg: RTL

- Parametrised WIDTH-bit universal shift register. Modes: hold, shift right, shift left, parallel load.
- Per-bit next-state mux logic is built structurally from 2-input CMOS NOR cells: pmos/nmos switch primitives on supply1/supply0 rails. Storage flops are behavioural.
- Also tracks the number of shifts performed since the last load.
- Used as the serial/parallel conversion element in the team's structural-modelling datapath set.

---
 rtl/nor_universal_shift_reg.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/nor_universal_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) whose next-state
// muxes are switch-level CMOS NOR cells. Define ROTATE_EN to add the rotate_sel port.
`timescale 1ns/1ps
module nor_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef ROTATE_EN
    input  logic             rotate_sel,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             full_shifted
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    supply1 vdd;
    supply0 gnd;

    wire [WIDTH-1:0] nxt;

    // Every NOR cell: two series pmos from vdd, two parallel nmos to gnd.
    // Select inverters are NOR cells with both inputs tied together.
    wire m0_n, m0_n_m, m1_n, m1_n_m;

    pmos m0_inv_p0 (m0_n_m, vdd, mode[0]);
    pmos m0_inv_p1 (m0_n, m0_n_m, mode[0]);
    nmos m0_inv_n0 (m0_n, gnd, mode[0]);
    nmos m0_inv_n1 (m0_n, gnd, mode[0]);

    pmos m1_inv_p0 (m1_n_m, vdd, mode[1]);
    pmos m1_inv_p1 (m1_n, m1_n_m, mode[1]);
    nmos m1_inv_n0 (m1_n, gnd, mode[1]);
    nmos m1_inv_n1 (m1_n, gnd, mode[1]);

`ifdef ROTATE_EN
    // Serial fill sources: rotate_sel swaps the external serial inputs for the opposite end of q.
    wire rot_n, rot_n_m;
    wire fr_a, fr_a_m, fr_b, fr_b_m, fill_r, fill_r_m;
    wire fl_a, fl_a_m, fl_b, fl_b_m, fill_l, fill_l_m;

    pmos rot_inv_p0 (rot_n_m, vdd, rotate_sel);
    pmos rot_inv_p1 (rot_n, rot_n_m, rotate_sel);
    nmos rot_inv_n0 (rot_n, gnd, rotate_sel);
    nmos rot_inv_n1 (rot_n, gnd, rotate_sel);

    pmos fr_a_p0 (fr_a_m, vdd, sin_r);
    pmos fr_a_p1 (fr_a, fr_a_m, rotate_sel);
    nmos fr_a_n0 (fr_a, gnd, sin_r);
    nmos fr_a_n1 (fr_a, gnd, rotate_sel);

    pmos fr_b_p0 (fr_b_m, vdd, q[0]);
    pmos fr_b_p1 (fr_b, fr_b_m, rot_n);
    nmos fr_b_n0 (fr_b, gnd, q[0]);
    nmos fr_b_n1 (fr_b, gnd, rot_n);

    pmos fr_y_p0 (fill_r_m, vdd, fr_a);
    pmos fr_y_p1 (fill_r, fill_r_m, fr_b);
    nmos fr_y_n0 (fill_r, gnd, fr_a);
    nmos fr_y_n1 (fill_r, gnd, fr_b);

    pmos fl_a_p0 (fl_a_m, vdd, sin_l);
    pmos fl_a_p1 (fl_a, fl_a_m, rotate_sel);
    nmos fl_a_n0 (fl_a, gnd, sin_l);
    nmos fl_a_n1 (fl_a, gnd, rotate_sel);

    pmos fl_b_p0 (fl_b_m, vdd, q[WIDTH-1]);
    pmos fl_b_p1 (fl_b, fl_b_m, rot_n);
    nmos fl_b_n0 (fl_b, gnd, q[WIDTH-1]);
    nmos fl_b_n1 (fl_b, gnd, rot_n);

    pmos fl_y_p0 (fill_l_m, vdd, fl_a);
    pmos fl_y_p1 (fill_l, fill_l_m, fl_b);
    nmos fl_y_n0 (fill_l, gnd, fl_a);
    nmos fl_y_n1 (fill_l, gnd, fl_b);
`endif

    // Per bit: two 2:1 muxes on mode[0] (hold/right, left/load) feeding a 2:1 on mode[1].
    // Each 2:1 mux is y = NOR(NOR(a, s), NOR(b, ~s)).
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            wire lo_a, lo_a_m, lo_b, lo_b_m, lo_y, lo_y_m;
            wire hi_a, hi_a_m, hi_b, hi_b_m, hi_y, hi_y_m;
            wire st_a, st_a_m, st_b, st_b_m, nxt_m;

            pmos lo_a_p0 (lo_a_m, vdd, q[i]);
            pmos lo_a_p1 (lo_a, lo_a_m, mode[0]);
            nmos lo_a_n0 (lo_a, gnd, q[i]);
            nmos lo_a_n1 (lo_a, gnd, mode[0]);

            if (i == WIDTH - 1) begin : g_msb
`ifdef ROTATE_EN
                pmos lo_b_p0 (lo_b_m, vdd, fill_r);
                pmos lo_b_p1 (lo_b, lo_b_m, m0_n);
                nmos lo_b_n0 (lo_b, gnd, fill_r);
                nmos lo_b_n1 (lo_b, gnd, m0_n);
`else
                pmos lo_b_p0 (lo_b_m, vdd, sin_r);
                pmos lo_b_p1 (lo_b, lo_b_m, m0_n);
                nmos lo_b_n0 (lo_b, gnd, sin_r);
                nmos lo_b_n1 (lo_b, gnd, m0_n);
`endif
            end else begin : g_inner_r
                pmos lo_b_p0 (lo_b_m, vdd, q[i+1]);
                pmos lo_b_p1 (lo_b, lo_b_m, m0_n);
                nmos lo_b_n0 (lo_b, gnd, q[i+1]);
                nmos lo_b_n1 (lo_b, gnd, m0_n);
            end

            pmos lo_y_p0 (lo_y_m, vdd, lo_a);
            pmos lo_y_p1 (lo_y, lo_y_m, lo_b);
            nmos lo_y_n0 (lo_y, gnd, lo_a);
            nmos lo_y_n1 (lo_y, gnd, lo_b);

            if (i == 0) begin : g_lsb
`ifdef ROTATE_EN
                pmos hi_a_p0 (hi_a_m, vdd, fill_l);
                pmos hi_a_p1 (hi_a, hi_a_m, mode[0]);
                nmos hi_a_n0 (hi_a, gnd, fill_l);
                nmos hi_a_n1 (hi_a, gnd, mode[0]);
`else
                pmos hi_a_p0 (hi_a_m, vdd, sin_l);
                pmos hi_a_p1 (hi_a, hi_a_m, mode[0]);
                nmos hi_a_n0 (hi_a, gnd, sin_l);
                nmos hi_a_n1 (hi_a, gnd, mode[0]);
`endif
            end else begin : g_inner_l
                pmos hi_a_p0 (hi_a_m, vdd, q[i-1]);
                pmos hi_a_p1 (hi_a, hi_a_m, mode[0]);
                nmos hi_a_n0 (hi_a, gnd, q[i-1]);
                nmos hi_a_n1 (hi_a, gnd, mode[0]);
            end

            pmos hi_b_p0 (hi_b_m, vdd, d[i]);
            pmos hi_b_p1 (hi_b, hi_b_m, m0_n);
            nmos hi_b_n0 (hi_b, gnd, d[i]);
            nmos hi_b_n1 (hi_b, gnd, m0_n);

            pmos hi_y_p0 (hi_y_m, vdd, hi_a);
            pmos hi_y_p1 (hi_y, hi_y_m, hi_b);
            nmos hi_y_n0 (hi_y, gnd, hi_a);
            nmos hi_y_n1 (hi_y, gnd, hi_b);

            pmos st_a_p0 (st_a_m, vdd, lo_y);
            pmos st_a_p1 (st_a, st_a_m, mode[1]);
            nmos st_a_n0 (st_a, gnd, lo_y);
            nmos st_a_n1 (st_a, gnd, mode[1]);

            pmos st_b_p0 (st_b_m, vdd, hi_y);
            pmos st_b_p1 (st_b, st_b_m, m1_n);
            nmos st_b_n0 (st_b, gnd, hi_y);
            nmos st_b_n1 (st_b, gnd, m1_n);

            pmos nxt_p0 (nxt_m, vdd, st_a);
            pmos nxt_p1 (nxt[i], nxt_m, st_b);
            nmos nxt_n0 (nxt[i], gnd, st_a);
            nmos nxt_n1 (nxt[i], gnd, st_b);
        end
    endgenerate

    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = shift_cnt;
        if (shift_cnt != CNT_MAX) begin
            cnt_inc = shift_cnt + CNT_ONE;
        end
    end

    // Mode only matters under en, so an unknown mode with en low leaves all state intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q            <= '0;
            shift_cnt    <= '0;
            full_shifted <= 1'b0;
        end else if (en) begin
            q <= nxt;
            case (mode)
                MODE_RIGHT, MODE_LEFT: begin
                    shift_cnt    <= cnt_inc;
                    full_shifted <= (cnt_inc >= CNT_FULL);
                end
                MODE_LOAD: begin
                    shift_cnt    <= '0;
                    full_shifted <= 1'b0;
                end
                default: begin
                    shift_cnt    <= shift_cnt;
                    full_shifted <= full_shifted;
                end
            endcase
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule
